// File: rtl/pipeline_pkg.sv
// Shared pipeline-control types and constants for the 5-stage core.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// EX-stage operand forwarding select for one source register; M beats W.
module forward_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] RsE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] Forward
);

    always_comb begin
        Forward = FWD_RF;
        if (RegWriteM && (RdM != REG_ZERO) && (RdM == RsE))
            Forward = FWD_M;
        else if (RegWriteW && (RdW != REG_ZERO) && (RdW == RsE))
            Forward = FWD_W;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: stall/flush priority mux, memory-wait FSM with
// timeout abort, stall-cycle counter, and EX forwarding selects.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        ResultSrcE0,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemFault,
    output logic [31:0] StallCnt
);

    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          mem_stall;
    logic          load_use;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;

    forward_unit u_fwd_a (
        .RsE       (Rs1E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .Forward   (fwd_a)
    );

    forward_unit u_fwd_b (
        .RsE       (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .Forward   (fwd_b)
    );

    assign mem_stall = MemReqM && !MemReadyM && (state != FAULT);
    assign load_use  = ResultSrcE0 && (RdE != REG_ZERO) && ((RdE == Rs1D) || (RdE == Rs2D));

    assign ForwardAE = reset ? FWD_RF : fwd_a;
    assign ForwardBE = reset ? FWD_RF : fwd_b;

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        FlushW = 1'b0;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
        end else if (state == FAULT) begin
            StallF = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
        end else if (mem_stall) begin
            // Branch and load-use are held off; they re-evaluate once M releases.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            cnt      <= '0;
            MemFault <= 1'b0;
            StallCnt <= '0;
        end else begin
            MemFault <= 1'b0;
            if (StallF)
                StallCnt <= StallCnt + 32'd1;
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state <= MEM_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!MemReqM || MemReadyM) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= FAULT;
                        MemFault <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FAULT: begin
                    state <= RUN;
                    cnt   <= '0;
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle reference model plus
// hand-computed directed expectations, using MEM_TIMEOUT=4.
module tb_hazard_ctrl;

    localparam int MT = 4;

    logic        clk;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushM, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemFault;
    logic [31:0] StallCnt;

    int passed = 0;
    int total  = 0;

    hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemFault(MemFault), .StallCnt(StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] ctl_vec();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};
    endfunction

    function automatic logic [1:0] fwd_rule(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Reference model: counts consecutive stalled cycles of the current access.
    int          m_waited = 0;
    bit          m_fault_now = 0;
    bit          m_pulse = 0;
    bit          m_valid = 0;
    logic [31:0] m_cnt = 0;

    always @(negedge clk) begin
        logic [7:0] exp_ctl;
        logic [3:0] exp_fwd;
        bit         hung;
        hung = MemReqM && !MemReadyM;
        exp_fwd = reset ? 4'b0000 : {fwd_rule(Rs1E), fwd_rule(Rs2E)};
        if (reset)
            exp_ctl = 8'b0000_1111;
        else if (m_fault_now)
            exp_ctl = 8'b1000_1111;
        else if (hung)
            exp_ctl = 8'b1111_0001;
        else if (PCSrcE)
            exp_ctl = 8'b0000_1100;
        else if (ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D))
            exp_ctl = 8'b1100_0100;
        else
            exp_ctl = 8'b0000_0000;

        check("model_ctl", {24'd0, ctl_vec()}, {24'd0, exp_ctl});
        check("model_fwd", {28'd0, ForwardAE, ForwardBE}, {28'd0, exp_fwd});
        if (m_valid) begin
            check("model_memfault", {31'd0, MemFault}, {31'd0, m_pulse});
            check("model_stallcnt", StallCnt, m_cnt);
        end

        if (reset) begin
            m_valid = 1; m_waited = 0; m_fault_now = 0; m_pulse = 0; m_cnt = 0;
        end else begin
            m_cnt   = m_cnt + {31'd0, exp_ctl[7]};
            m_pulse = 0;
            if (m_fault_now) begin
                m_fault_now = 0;
                m_waited = 0;
            end else if (hung) begin
                m_waited++;
                if (m_waited == MT) begin
                    m_fault_now = 1;
                    m_pulse = 1;
                    m_waited = 0;
                end
            end else begin
                m_waited = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        Rs1E = 5; RdM = 5; RegWriteM = 1; MemReqM = 1;
        settle();
        check("reset_ctl", {24'd0, ctl_vec()}, 32'h0F);
        check("reset_fwd", {30'd0, ForwardAE}, 32'd0);
        cyc(); cyc();
        reset = 0; clear_inputs();
        settle();
        check("post_reset_stallcnt", StallCnt, 32'd0);
        check("post_reset_memfault", {31'd0, MemFault}, 32'd0);

        // Forwarding
        cyc(); Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        settle(); check("fwd_a_m", {30'd0, ForwardAE}, 32'd2);
        cyc(); RdM = 6;
        settle(); check("fwd_a_w", {30'd0, ForwardAE}, 32'd1);
        cyc(); Rs2E = 0; RdM = 0; RdW = 0;
        settle(); check("fwd_b_x0", {30'd0, ForwardBE}, 32'd0);
        cyc(); Rs2E = 9; RdW = 9; RegWriteW = 1; RdM = 9; RegWriteM = 0;
        settle(); check("fwd_b_w_no_m", {30'd0, ForwardBE}, 32'd1);
        cyc(); clear_inputs();

        // Load-use
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        settle(); check("load_use_ctl", {24'd0, ctl_vec()}, 32'hC4);
        cyc(); clear_inputs();
        settle(); check("load_use_cnt", StallCnt, 32'd1);
        cyc(); ResultSrcE0 = 1; RdE = 0; Rs1D = 0;
        settle(); check("load_use_x0", {24'd0, ctl_vec()}, 32'h00);
        cyc(); ResultSrcE0 = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
        settle(); check("load_use_branch", {24'd0, ctl_vec()}, 32'h0C);
        cyc(); clear_inputs();

        // Ready after 3 cycles with branch pending
        MemReqM = 1; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            settle(); check("memwait_ctl", {24'd0, ctl_vec()}, 32'hF1);
            cyc();
        end
        MemReadyM = 1;
        settle(); check("memwait_release", {24'd0, ctl_vec()}, 32'h0C);
        cyc(); clear_inputs();
        settle(); check("memwait_cnt", StallCnt, 32'd4);

        // Ready in the same cycle as the request
        cyc(); MemReqM = 1; MemReadyM = 1;
        settle(); check("mem_ready_now", {24'd0, ctl_vec()}, 32'h00);
        cyc(); clear_inputs();

        // Timeout
        MemReqM = 1;
        for (int i = 0; i < MT; i++) begin
            settle(); check("timeout_stall", {24'd0, ctl_vec()}, 32'hF1);
            cyc();
        end
        MemReqM = 0;
        settle();
        check("fault_ctl", {24'd0, ctl_vec()}, 32'h8F);
        check("fault_pulse", {31'd0, MemFault}, 32'd1);
        cyc();
        settle();
        check("fault_done_ctl", {24'd0, ctl_vec()}, 32'h00);
        check("fault_pulse_end", {31'd0, MemFault}, 32'd0);
        check("fault_cnt", StallCnt, 32'd9);

        // Reset in the 2nd MEM_WAIT cycle
        cyc(); MemReqM = 1;
        settle(); cyc(); settle(); cyc();
        reset = 1;
        settle(); check("reset_mid_ctl", {24'd0, ctl_vec()}, 32'h0F);
        cyc(); reset = 0; MemReqM = 0;
        settle();
        check("reset_mid_cnt", StallCnt, 32'd0);
        check("reset_mid_pulse", {31'd0, MemFault}, 32'd0);
        check("reset_mid_ctl_after", {24'd0, ctl_vec()}, 32'h00);

        // Full timeout again proves the wait counter restarted from zero
        cyc(); MemReqM = 1;
        for (int i = 0; i < MT; i++) begin
            settle(); check("timeout2_stall", {24'd0, ctl_vec()}, 32'hF1);
            cyc();
        end
        MemReqM = 0;
        settle(); check("fault2_pulse", {31'd0, MemFault}, 32'd1);
        cyc();
        settle(); check("fault2_cnt", StallCnt, 32'd5);

        // Request withdrawn while waiting
        cyc(); MemReqM = 1;
        settle(); cyc(); settle(); cyc();
        MemReqM = 0;
        settle(); check("withdraw_ctl", {24'd0, ctl_vec()}, 32'h00);
        cyc();
        settle(); check("withdraw_pulse", {31'd0, MemFault}, 32'd0);

        cyc();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit for the 5-stage RISC-V core. Generates per-stage stall and flush controls and EX-stage forwarding selects for the F/D/E/M/W pipeline registers. Handles load-use, taken-branch and variable-latency data-memory hazards. Owns a small FSM that sequences memory-wait stalls, aborts hung accesses after a timeout, and counts stall cycles for performance monitoring.

## Interface
- MEM_TIMEOUT, 16: max stalled cycles for one data-memory access before abort; legal ≥ 2
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- Rs1D, Rs2D  in  5  source regs of instruction in D
- Rs1E, Rs2E  in  5  source regs of instruction in E
- RdE, RdM, RdW  in  5  destination regs in E/M/W
- ResultSrcE0  in  1  instruction in E is a load
- RegWriteM, RegWriteW  in  1  M/W instruction writes the register file
- PCSrcE  in  1  taken branch/jump resolved in E
- MemReqM  in  1  instruction in M accesses data memory
- MemReadyM  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushM, FlushW  out  1  load a bubble into the corresponding pipeline register
- ForwardAE, ForwardBE  out  2  00 = regfile, 01 = W result, 10 = M ALU result
- MemFault  out  1  registered one-cycle pulse: access aborted on timeout
- StallCnt  out  32  cycles with StallF=1; wraps modulo 2^32

## Operation
- States: RUN, MEM_WAIT, FAULT. Wait counter cnt has width $clog2(MEM_TIMEOUT).
- memStall is combinational: (MemReqM & ~MemReadyM) in RUN or MEM_WAIT.
- Forwarding is always active and combinational.
  - ForwardAE = 10 if RegWriteM & RdM≠0 & RdM==Rs1E; else 01 if RegWriteW & RdW≠0 & RdW==Rs1E; else 00.
  - ForwardBE follows the same rule on Rs2E. M beats W.
- loadUse = ResultSrcE0 & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- Priority (highest first):
  - FAULT: FlushD/E/M/W=1, StallF=1, other stalls 0.
  - memStall: StallF/D/E/M=1, FlushW=1, FlushD/E/M=0. Branch and load-use actions are suppressed and re-evaluate when the stall releases.
  - PCSrcE: FlushD=1, FlushE=1, no stalls. This overrides loadUse, because D holds a wrong-path instruction.
  - loadUse: StallF=1, StallD=1, FlushE=1.
  - Otherwise: all 0.
- Transitions:
  - RUN → MEM_WAIT on memStall, with cnt←1.
  - MEM_WAIT, MemReadyM=1 → RUN, cnt←0. Stall drops in the same cycle.
  - MEM_WAIT, MemReadyM=0, cnt==MEM_TIMEOUT−1 → FAULT.
  - MEM_WAIT, MemReadyM=0, otherwise → cnt++.
  - MEM_WAIT, MemReqM=0 (defensive) → RUN.
  - FAULT → RUN unconditionally, cnt←0.
- MemFault is 1 exactly during the cycle after the FAULT entry edge, i.e. registered on the transition into FAULT.
- StallCnt increments every non-reset cycle with StallF=1, including FAULT.

## Timing
- Stall, flush and forward outputs are combinational from inputs and state. Zero latency.
- A hung access gets exactly MEM_TIMEOUT stalled cycles: the RUN cycle plus MEM_TIMEOUT−1 MEM_WAIT cycles. FAULT follows in the next cycle.
- A ready-after-N access stalls N cycles. MemReadyM in the same cycle as MemReqM gives no stall.
- Reset:
  - During reset=1: all stalls 0, FlushD/E/M/W=1, forwards 00.
  - After the edge: state RUN, cnt 0, MemFault 0, StallCnt 0.
  - Reset during MEM_WAIT or FAULT aborts cleanly with no MemFault pulse.
- Reset forces the outputs above, and reset takes precedence over every other input.

## Structure
- Shared package pipeline_pkg:
  - state enum (RUN, MEM_WAIT, FAULT)
  - forward-select constants FWD_RF=00, FWD_W=01, FWD_M=10
  - REG_ZERO=5'd0
- Sub-module forward_unit is natural. It is purely combinational, instanced twice (A and B operands), with inputs RsE, RdM, RdW, RegWriteM, RegWriteW and output Forward[1:0].
- The FSM, counter and priority mux stay in hazard_ctrl.

## Test plan
- Forwarding:
  - Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 → ForwardAE=10.
  - Same with RdM=6 → 01.
  - Rs2E=0, RdM=0 → ForwardBE=00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for one cycle; StallCnt +1.
- Load-use with PCSrcE=1 in the same cycle → FlushD=FlushE=1, StallF=0.
- Memory wait: MemReqM=1, MemReadyM low for 3 cycles then high → StallF/D/E/M=1 and FlushW=1 for exactly 3 cycles, state back to RUN, StallCnt=3. A PCSrcE held high throughout flushes D/E only on the release cycle.
- Timeout with MEM_TIMEOUT=4 and MemReadyM never asserted → 4 stall cycles, then one FAULT cycle with FlushD/E/M/W=1 and StallF=1, MemFault pulse for 1 cycle, then RUN.
- Reset asserted in the 2nd MEM_WAIT cycle → next cycle RUN, cnt=0, StallCnt=0, no MemFault. Flushes are asserted while reset is high.
